alu_seq: RTL

Parametrised, registered ALU with a start/valid handshake and a multi-cycle unsigned shift-add multiplier. It generalises the per-bit ALU slice to a WIDTH-bit word with registered flags. It sits between the register-file read stage and write-back of the single-cycle/pipelined CPU labs. Single-cycle ops complete in one clock; MUL stalls the issuer via `busy`.

---
 rtl/alu_pkg.sv | 18 +
 rtl/alu_comb.sv | 49 ++++
 rtl/alu_seq.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared operation codes and FSM state encoding for the sequential ALU.
package alu_pkg;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1100;
  localparam logic [3:0] OP_MUL = 4'b1000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/alu_comb.sv
// Combinational WIDTH-bit ALU datapath: logic ops, add/sub, set-less-than.
module alu_comb
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CW    = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [CW-1:0]    ctrl,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow
);

  localparam int unsigned SW = WIDTH + 1;

  logic             sub_op;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum;
  logic             ovf;

  // SUB and SLT share the A + ~B + 1 adder path
  always_comb begin
    sub_op   = (ctrl == CW'(OP_SUB)) || (ctrl == CW'(OP_SLT));
    b_eff    = sub_op ? ~b : b;
    sum      = {1'b0, a} + {1'b0, b_eff} + SW'(sub_op);
    ovf      = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    result   = '0;
    cout     = 1'b0;
    overflow = 1'b0;
    case (ctrl)
      CW'(OP_AND): result = a & b;
      CW'(OP_OR):  result = a | b;
      CW'(OP_NOR): result = ~(a | b);
      CW'(OP_ADD), CW'(OP_SUB): begin
        result   = sum[WIDTH-1:0];
        cout     = sum[WIDTH];
        overflow = ovf;
      end
      CW'(OP_SLT): begin
        result = WIDTH'(sum[WIDTH-1] ^ ovf);
        cout   = sum[WIDTH];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with start/valid handshake and a shift-add multiplier that
// stalls the issuer through busy_o.
module alu_seq
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CW    = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [CW-1:0]    ctrl_i,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  output logic [WIDTH-1:0] result_o,
  output logic [WIDTH-1:0] result_hi_o,
  output logic             zero_o,
  output logic             cout_o,
  output logic             overflow_o,
  output logic             busy_o,
  output logic             valid_o
);

  localparam int unsigned CNTW = $clog2(WIDTH + 1);

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  mcand_q, mcand_d;
  logic [WIDTH-1:0]  mplier_q, mplier_d;
  logic [WIDTH-1:0]  acc_q, acc_d;
  logic [CNTW-1:0]   count_q, count_d;
  logic [WIDTH-1:0]  result_d, result_hi_d;
  logic              zero_d, cout_d, overflow_d, busy_d, valid_d;

  logic [WIDTH-1:0]  alu_a, alu_b, alu_res;
  logic [CW-1:0]     alu_ctrl;
  logic              alu_cout, alu_ovf;
  logic [WIDTH-1:0]  step_sum;
  logic              step_carry;

  // During MUL the datapath is borrowed to add the multiplicand into acc
  assign alu_a    = (state_q == ST_MUL) ? acc_q      : src1_i;
  assign alu_b    = (state_q == ST_MUL) ? mcand_q    : src2_i;
  assign alu_ctrl = (state_q == ST_MUL) ? CW'(OP_ADD) : ctrl_i;

  alu_comb #(.WIDTH(WIDTH), .CW(CW)) u_alu_comb (
    .a        (alu_a),
    .b        (alu_b),
    .ctrl     (alu_ctrl),
    .result   (alu_res),
    .cout     (alu_cout),
    .overflow (alu_ovf)
  );

  always_comb begin
    state_d     = state_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    acc_d       = acc_q;
    count_d     = count_q;
    result_d    = result_o;
    result_hi_d = result_hi_o;
    zero_d      = zero_o;
    cout_d      = cout_o;
    overflow_d  = overflow_o;
    busy_d      = 1'b0;
    valid_d     = 1'b0;
    step_carry  = mplier_q[0] ? alu_cout : 1'b0;
    step_sum    = mplier_q[0] ? alu_res  : acc_q;
    case (state_q)
      ST_MUL: begin
        busy_d   = 1'b1;
        acc_d    = {step_carry, step_sum[WIDTH-1:1]};
        mplier_d = {step_sum[0], mplier_q[WIDTH-1:1]};
        count_d  = count_q - CNTW'(1);
        if (count_q == CNTW'(1)) begin
          state_d     = ST_DONE;
          busy_d      = 1'b0;
          valid_d     = 1'b1;
          result_d    = mplier_d;
          result_hi_d = acc_d;
          zero_d      = (mplier_d == '0);
          cout_d      = 1'b0;
          overflow_d  = 1'b0;
        end
      end
      default: begin
        // IDLE and DONE both accept a new request
        state_d = ST_IDLE;
        if (start_i) begin
          if (ctrl_i == CW'(OP_MUL)) begin
            state_d  = ST_MUL;
            busy_d   = 1'b1;
            mcand_d  = src1_i;
            mplier_d = src2_i;
            acc_d    = '0;
            count_d  = CNTW'(WIDTH);
          end else begin
            valid_d     = 1'b1;
            result_d    = alu_res;
            result_hi_d = '0;
            zero_d      = (alu_res == '0);
            cout_d      = alu_cout;
            overflow_d  = alu_ovf;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
      count_q     <= '0;
      result_o    <= '0;
      result_hi_o <= '0;
      zero_o      <= 1'b1;
      cout_o      <= 1'b0;
      overflow_o  <= 1'b0;
      busy_o      <= 1'b0;
      valid_o     <= 1'b0;
    end else begin
      state_q     <= state_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      acc_q       <= acc_d;
      count_q     <= count_d;
      result_o    <= result_d;
      result_hi_o <= result_hi_d;
      zero_o      <= zero_d;
      cout_o      <= cout_d;
      overflow_o  <= overflow_d;
      busy_o      <= busy_d;
      valid_o     <= valid_d;
    end
  end

endmodule
